// File: rtl/sum_uart_sequencer.sv
// Operand capture, A+B sum, decimal-ASCII conversion and UART start/busy handshake.
// Build option CRLF_EN: when defined each message also carries CR, LF after the digits.
module sum_uart_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              save_a_n,
    input  logic              save_b_n,
    input  logic [DATA_W-1:0] data_input,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              seq_busy,
    output logic [DATA_W:0]   sum_out
);
    // state | meaning
    // IDLE  | waiting for both operands valid; commit sum and digits
    // LOAD  | drive tx_data with the current byte
    // REQ   | wait for transmitter idle, then pulse tx_start
    // ACK   | wait for transmitter to report busy
    // DONE  | wait for busy to drop; next byte or back to IDLE
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_ACK, S_DONE} state_t;

    localparam int SW       = DATA_W + 1;
    localparam int TENS_MAX = ((2 ** SW) - 2) / 10;
`ifdef CRLF_EN
    localparam int NBYTES = 4;
`else
    localparam int NBYTES = 2;
`endif
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
    logic                   prev_a_q, prev_b_q;
    logic                   fall_a, fall_b;

    state_t           state_q;
    logic [DATA_W-1:0] reg_a_q, reg_b_q;
    logic             a_valid_q, b_valid_q;
    logic [IDX_W-1:0] byte_idx_q;
    logic [SW-1:0]    tens_q, units_q, sum_q;
    logic             tx_start_q, seq_busy_q;
    logic [7:0]       tx_data_q;

    logic             commit;
    logic [SW-1:0]    sum_d, rem_d, tens_d;
    logic [7:0]       byte_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a_q <= '1;
            sync_b_q <= '1;
            prev_a_q <= 1'b1;
            prev_b_q <= 1'b1;
        end else begin
            sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], save_a_n};
            sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], save_b_n};
            prev_a_q <= sync_a_q[SYNC_STAGES-1];
            prev_b_q <= sync_b_q[SYNC_STAGES-1];
        end
    end

    assign fall_a = prev_a_q & ~sync_a_q[SYNC_STAGES-1];
    assign fall_b = prev_b_q & ~sync_b_q[SYNC_STAGES-1];
    assign commit = (state_q == S_IDLE) & a_valid_q & b_valid_q;
    assign sum_d  = SW'(reg_a_q) + SW'(reg_b_q);

    // Divide by ten as a fixed chain of compare-subtract steps.
    always_comb begin
        rem_d  = sum_d;
        tens_d = '0;
        for (int i = 0; i < TENS_MAX; i++) begin
            if (rem_d >= SW'(10)) begin
                rem_d  = rem_d - SW'(10);
                tens_d = tens_d + SW'(1);
            end
        end
    end

    always_comb begin
        byte_d = 8'h30 + 8'(tens_q);
        if (byte_idx_q == IDX_W'(1)) begin
            byte_d = 8'h30 + 8'(units_q);
        end
`ifdef CRLF_EN
        else if (byte_idx_q == IDX_W'(2)) begin
            byte_d = 8'h0D;
        end else if (byte_idx_q == IDX_W'(3)) begin
            byte_d = 8'h0A;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            reg_a_q    <= '0;
            reg_b_q    <= '0;
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            byte_idx_q <= '0;
            tens_q     <= '0;
            units_q    <= '0;
            sum_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            seq_busy_q <= 1'b0;
        end else begin
            if (fall_a) reg_a_q <= data_input;
            if (fall_b) reg_b_q <= data_input;
            // A capture on the commit cycle survives as a fresh operand.
            a_valid_q  <= fall_a | (a_valid_q & ~commit);
            b_valid_q  <= fall_b | (b_valid_q & ~commit);
            tx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (commit) begin
                        sum_q      <= sum_d;
                        tens_q     <= tens_d;
                        units_q    <= rem_d;
                        byte_idx_q <= '0;
                        seq_busy_q <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tx_data_q <= byte_d;
                    state_q   <= S_REQ;
                end
                S_REQ: begin
                    if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        state_q    <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (tx_busy) state_q <= S_DONE;
                end
                S_DONE: begin
                    if (!tx_busy) begin
                        if (byte_idx_q == LAST_IDX) begin
                            seq_busy_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            byte_idx_q <= byte_idx_q + IDX_W'(1);
                            state_q    <= S_LOAD;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign seq_busy = seq_busy_q;
    assign sum_out  = sum_q;

endmodule

// File: tb/tb_sum_uart_sequencer.sv
// Randomized and directed bench for sum_uart_sequencer against a queue-based message model.
// Honours CRLF_EN the same way as the design (4-byte messages when defined).
module tb_sum_uart_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       save_a_n = 1'b1;
    logic       save_b_n = 1'b1;
    logic [3:0] data_input = 4'd0;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       seq_busy;
    logic [4:0] sum_out;

    logic       xmit_busy = 1'b0;
    logic       hold_busy = 1'b0;
    int         busy_len = 20;
    int         busy_cnt = 0;
    logic [7:0] cur_byte = 8'h00;
    int         extra_pulses = 0;
    int         unstable = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    assign tx_busy = xmit_busy | hold_busy;

    sum_uart_sequencer dut (
        .clk(clk), .reset(reset), .save_a_n(save_a_n), .save_b_n(save_b_n),
        .data_input(data_input), .tx_busy(tx_busy), .tx_start(tx_start),
        .tx_data(tx_data), .seq_busy(seq_busy), .sum_out(sum_out)
    );

    always #5 clk = ~clk;

    // Transmitter model: takes a byte on tx_start, stays busy for busy_len cycles.
    always @(negedge clk) begin
        if (reset) begin
            xmit_busy = 1'b0;
            busy_cnt  = 0;
        end else if (xmit_busy) begin
            if (tx_start) extra_pulses++;
            if (tx_data != cur_byte) unstable++;
            busy_cnt--;
            if (busy_cnt <= 0) xmit_busy = 1'b0;
        end else if (tx_start) begin
            if (hold_busy) extra_pulses++;
            rx_q.push_back(tx_data);
            cur_byte  = tx_data;
            xmit_busy = 1'b1;
            busy_cnt  = busy_len;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic expect_msg(input int a, input int b);
        int s;
        s = a + b;
        exp_q.push_back(8'(8'h30 + s / 10));
        exp_q.push_back(8'(8'h30 + s % 10));
`ifdef CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic compare_bytes();
        int obs;
        check("nbytes", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < rx_q.size()) ? int'(rx_q[i]) : -1;
            check($sformatf("byte%0d", i), obs, int'(exp_q[i]));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic strobe(input logic [3:0] v, input bit do_a, input bit do_b);
        @(negedge clk);
        data_input = v;
        if (do_a) save_a_n = 1'b0;
        if (do_b) save_b_n = 1'b0;
        repeat (4) @(negedge clk);
        save_a_n = 1'b1;
        save_b_n = 1'b1;
    endtask

    task automatic wait_msg(input int exp_sum, input bit lat);
        int n;
        n = 0;
        while (!seq_busy && n < 200) begin @(negedge clk); n++; end
        check("seq_busy_rise", seq_busy, 1);
        if (lat) begin
            n = 0;
            while (!tx_start && n < 50) begin @(negedge clk); n++; end
            check("start_latency", n, 2);
        end
        n = 0;
        while (seq_busy && n < 3000) begin @(negedge clk); n++; end
        check("seq_busy_fall", seq_busy, 0);
        check("sum_out", sum_out, exp_sum);
    endtask

    initial begin
        int bad, a, b, mode, n;
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_seq_busy", seq_busy, 0);
        check("rst_sum_out", sum_out, 0);
        check("rst_tx_data", tx_data, 0);
        reset = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_start || seq_busy || sum_out != 0) bad++;
        end
        check("idle_quiet", bad, 0);

        busy_len = 20;
        strobe(4'd7, 1, 0); strobe(4'd9, 0, 1);
        expect_msg(7, 9); wait_msg(16, 1); compare_bytes();

        strobe(4'd15, 1, 0); strobe(4'd15, 0, 1);
        expect_msg(15, 15); wait_msg(30, 1); compare_bytes();
        strobe(4'd0, 1, 0); strobe(4'd0, 0, 1);
        expect_msg(0, 0); wait_msg(0, 1); compare_bytes();

        strobe(4'd1, 1, 0); strobe(4'd6, 1, 0); strobe(4'd2, 0, 1);
        expect_msg(6, 2); wait_msg(8, 1); compare_bytes();

        hold_busy = 1'b1;
        strobe(4'd5, 1, 1);
        expect_msg(5, 5);
        repeat (30) @(negedge clk);
        check("held_no_start", rx_q.size(), 0);
        check("held_seq_busy", seq_busy, 1);
        hold_busy = 1'b0;
        wait_msg(10, 0); compare_bytes();

        strobe(4'd7, 1, 0); strobe(4'd9, 0, 1);
        expect_msg(7, 9);
        strobe(4'd2, 1, 0); strobe(4'd2, 0, 1);
        expect_msg(2, 2);
        wait_msg(16, 0); wait_msg(4, 0); compare_bytes();

        for (int it = 0; it < 20; it++) begin
            busy_len = $urandom_range(1, 25);
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                strobe(4'(a), 1, 0); strobe(4'(b), 0, 1);
            end else if (mode == 1) begin
                strobe(4'(b), 0, 1); strobe(4'(a), 1, 0);
            end else begin
                b = a;
                strobe(4'(a), 1, 1);
            end
            expect_msg(a, b); wait_msg(a + b, 1); compare_bytes();
        end

        busy_len = 20;
        strobe(4'd2, 1, 0); strobe(4'd3, 0, 1);
        n = 0;
        while (!tx_start && n < 20) begin @(negedge clk); n++; end
        check("pre_reset_start", tx_start, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_tx_start", tx_start, 0);
        check("mid_rst_seq_busy", seq_busy, 0);
        check("mid_rst_sum_out", sum_out, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rx_q.delete();
        exp_q.delete();
        repeat (100) @(negedge clk);
        check("no_bytes_after_rst", rx_q.size(), 0);
        check("idle_after_rst", seq_busy, 0);
        strobe(4'd3, 1, 0); strobe(4'd4, 0, 1);
        expect_msg(3, 4); wait_msg(7, 1); compare_bytes();

        check("extra_pulses", extra_pulses, 0);
        check("tx_data_unstable", unstable, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
